// File: rtl/alarm_setter.sv
// alarm_setter: front-panel editor for the alarm preset (BCD hour/minute) with a timed load strobe
module alarm_setter #(
   parameter int TIMEOUT      = 5000,
   parameter int PE_CYCLES    = 4,
   parameter int REPEAT_DELAY = 500,
   parameter int REPEAT_RATE  = 100
) (
   input  logic       CP,
   input  logic       CR_N,
   input  logic       KEY_MODE,
   input  logic       KEY_INC,
   input  logic       KEY_OK,
   input  logic [7:0] BFM_H,
   input  logic [7:0] BFM_M,
   output logic [7:0] D_H,
   output logic [7:0] D_M,
   output logic [7:0] D_S,
   output logic       PE,
   output logic [1:0] EDIT
);
   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] EDIT_H = 2'b01;
   localparam logic [1:0] EDIT_M = 2'b10;
   localparam logic [1:0] LOAD   = 2'b11;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int RW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
   localparam int PW = $clog2(PE_CYCLES + 1);

   logic [1:0]    state, nxt;
   logic          mode_q, inc_q, ok_q, armed, rep_phase, keep;
   logic          p_ok, p_mode, p_inc, editing, rep, inc_ev, pe_last, h_ok, m_ok;
   logic [TW-1:0] idle_cnt;
   logic [RW-1:0] hold_cnt;
   logic [PW-1:0] pe_cnt;
   logic [7:0]    h_inc, m_inc;

   assign editing = state == EDIT_H || state == EDIT_M;
   assign p_ok    = KEY_OK & ~ok_q;
   assign p_mode  = KEY_MODE & ~mode_q & ~p_ok;
   assign p_inc   = KEY_INC & ~inc_q & ~p_ok & ~p_mode;
   assign rep     = editing & armed & KEY_INC & ~p_ok & ~p_mode &
                    (hold_cnt == (rep_phase ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY)));
   assign inc_ev  = editing & (p_inc | rep);
   assign pe_last = pe_cnt == PW'(PE_CYCLES - 1);
   assign nxt     = state == IDLE ? (p_mode ? EDIT_H : IDLE) :
                    state == LOAD ? (pe_last ? IDLE : LOAD) :
                    p_ok ? LOAD :
                    p_mode ? (state == EDIT_H ? EDIT_M : EDIT_H) :
                    (!inc_ev && idle_cnt == TW'(TIMEOUT - 1)) ? IDLE : state;
   // auto-repeat stays armed only while INC is held in the field where it was pressed
   assign keep    = editing && nxt == state && KEY_INC && (p_inc || armed);
   assign h_ok    = BFM_H <= 8'h23 && BFM_H[3:0] <= 4'h9;
   assign m_ok    = BFM_M <= 8'h59 && BFM_M[3:0] <= 4'h9;
   assign h_inc   = D_H == 8'h23 ? 8'h00 : D_H[3:0] == 4'h9 ? {D_H[7:4] + 4'h1, 4'h0} : D_H + 8'h01;
   assign m_inc   = D_M == 8'h59 ? 8'h00 : D_M[3:0] == 4'h9 ? {D_M[7:4] + 4'h1, 4'h0} : D_M + 8'h01;
   assign EDIT    = state;
   assign D_S     = 8'h00;

   // Key history, state, hold/idle/load timers and the registered load strobe
   always_ff @(posedge CP) begin
      if (!CR_N) begin
         {mode_q, inc_q, ok_q} <= 3'b000;
         state     <= IDLE;
         PE        <= 1'b0;
         armed     <= 1'b0;
         rep_phase <= 1'b0;
         idle_cnt  <= '0;
         hold_cnt  <= '0;
         pe_cnt    <= '0;
      end else begin
         {mode_q, inc_q, ok_q} <= {KEY_MODE, KEY_INC, KEY_OK};
         state     <= nxt;
         PE        <= nxt == LOAD;
         armed     <= keep;
         rep_phase <= keep & ~p_inc & (rep_phase | rep);
         idle_cnt  <= (!editing || nxt != state || inc_ev) ? '0 : idle_cnt + 1'b1;
         hold_cnt  <= !keep ? '0 : (p_inc || rep) ? RW'(1) : hold_cnt + 1'b1;
         pe_cnt    <= state == LOAD ? pe_cnt + 1'b1 : '0;
      end
   end

   // Working time: sanitised capture on edit entry, BCD step on increment events
   always_ff @(posedge CP) begin
      if (!CR_N) begin
         D_H <= 8'h00;
         D_M <= 8'h00;
      end else if (state == IDLE && p_mode) begin
         D_H <= h_ok ? BFM_H : 8'h00;
         D_M <= m_ok ? BFM_M : 8'h00;
      end else if (inc_ev) begin
         D_H <= state == EDIT_H ? h_inc : D_H;
         D_M <= state == EDIT_M ? m_inc : D_M;
      end
   end
endmodule

// File: tb/tb_alarm_setter.sv
// tb_alarm_setter: directed scenarios plus random key traffic against a cycle-level behavioural model
module tb_alarm_setter;
   localparam int TIMEOUT = 5000, PE_CYCLES = 4, REPEAT_DELAY = 500, REPEAT_RATE = 100;

   logic       CP = 1'b0, CR_N = 1'b0, KEY_MODE = 1'b0, KEY_INC = 1'b0, KEY_OK = 1'b0;
   logic [7:0] BFM_H = 8'h00, BFM_M = 8'h00;
   logic [7:0] D_H, D_M, D_S;
   logic       PE;
   logic [1:0] EDIT;
   int         vectors = 0, miscompares = 0;

   // model: mode 0 idle, 1 hour, 2 minute, 3 loading; hour/minute kept as plain integers
   int   m_mode = 0, m_h = 0, m_m = 0, m_left = 0, m_since = 0, m_held = -1;
   logic m_pmode = 1'b0, m_pinc = 1'b0, m_pok = 1'b0;

   alarm_setter #(.TIMEOUT(TIMEOUT), .PE_CYCLES(PE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                  .REPEAT_RATE(REPEAT_RATE)) dut (
      .CP(CP), .CR_N(CR_N), .KEY_MODE(KEY_MODE), .KEY_INC(KEY_INC), .KEY_OK(KEY_OK),
      .BFM_H(BFM_H), .BFM_M(BFM_M), .D_H(D_H), .D_M(D_M), .D_S(D_S), .PE(PE), .EDIT(EDIT)
   );

   always #5 CP = ~CP;

   function automatic logic [7:0] bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic int cap(input logic [7:0] b, input int lim);
      int hi, lo;
      hi = int'(b[7:4]);
      lo = int'(b[3:0]);
      return (hi <= 9 && lo <= 9 && hi * 10 + lo <= lim) ? hi * 10 + lo : 0;
   endfunction

   function automatic logic [26:0] expv();
      return {bcd(m_h), bcd(m_m), 8'h00, m_mode == 3, 2'(m_mode)};
   endfunction

   task automatic step();
      logic po, pm, pi, ev;
      po = KEY_OK & ~m_pok;
      pm = KEY_MODE & ~m_pmode & ~po;
      pi = KEY_INC & ~m_pinc & ~po & ~pm;
      ev = 1'b0;
      if (!CR_N) begin
         m_mode = 0; m_h = 0; m_m = 0; m_left = 0; m_since = 0; m_held = -1;
      end else if (m_mode == 0) begin
         if (pm) begin
            m_h = cap(BFM_H, 23); m_m = cap(BFM_M, 59); m_mode = 1; m_since = 0; m_held = -1;
         end
      end else if (m_mode == 3) begin
         m_left--;
         if (m_left == 0) m_mode = 0;
      end else if (po) begin
         m_mode = 3; m_left = PE_CYCLES; m_held = -1;
      end else if (pm) begin
         m_mode = 3 - m_mode; m_since = 0; m_held = -1;
      end else begin
         if (pi) begin
            m_held = 0; ev = 1'b1;
         end else if (m_held >= 0 && KEY_INC) begin
            m_held++;
            ev = m_held >= REPEAT_DELAY && (m_held - REPEAT_DELAY) % REPEAT_RATE == 0;
         end else m_held = -1;
         if (ev) begin
            if (m_mode == 1) m_h = (m_h + 1) % 24;
            else m_m = (m_m + 1) % 60;
            m_since = 0;
         end else if (m_since == TIMEOUT - 1) begin
            m_mode = 0; m_held = -1;
         end else m_since++;
      end
      m_pmode = CR_N & KEY_MODE;
      m_pinc  = CR_N & KEY_INC;
      m_pok   = CR_N & KEY_OK;
   endtask

   task automatic tick();
      @(posedge CP);
      step();
      #1;
   endtask

   task automatic press(input int k);
      if (k == 0) KEY_MODE = 1'b1; else if (k == 1) KEY_INC = 1'b1; else KEY_OK = 1'b1;
      tick();
      KEY_MODE = 1'b0; KEY_INC = 1'b0; KEY_OK = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      KEY_MODE = 1'b0; KEY_INC = 1'b0; KEY_OK = 1'b0;
      CR_N = 1'b0;
      tick();
      CR_N = 1'b1;
   endtask

   task automatic test_reset();
      CR_N = 1'b0;
      tick();
      tick();
      vectors++;
      if ({D_H, D_M, D_S, PE, EDIT} !== 27'h0) begin
         miscompares++;
         $display("FAIL reset: got %h expected %h", {D_H, D_M, D_S, PE, EDIT}, 27'h0);
      end
      CR_N = 1'b1; BFM_H = 8'h07; BFM_M = 8'h30;
      press(0);
      vectors++;
      if ({D_H, D_M, EDIT} !== {8'h07, 8'h30, 2'b01}) begin
         miscompares++;
         $display("FAIL capture: got %h/%h/%b expected 07/30/01", D_H, D_M, EDIT);
      end
   endtask

   task automatic test_hour_wrap_commit();
      int hi;
      logic [7:0] want [5];
      do_reset();
      BFM_H = 8'h22; BFM_M = 8'h58;
      press(0);
      want = '{8'h23, 8'h00, 8'h59, 8'h00, 8'h01};
      for (int i = 0; i < 5; i++) begin
         if (i == 2) press(0);
         press(1);
         vectors++;
         if ((i < 2 ? D_H : D_M) !== want[i]) begin
            miscompares++;
            $display("FAIL bcd_step%0d: got %h expected %h", i, i < 2 ? D_H : D_M, want[i]);
         end
      end
      KEY_OK = 1'b1;
      hi = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         KEY_OK = 1'b0;
         if (PE) begin
            hi++;
            vectors++;
            if ({D_H, D_M, D_S} !== 24'h000100) begin
               miscompares++;
               $display("FAIL load_data: got %h expected 000100", {D_H, D_M, D_S});
            end
         end
      end
      vectors++;
      if (hi !== PE_CYCLES || EDIT !== 2'b00) begin
         miscompares++;
         $display("FAIL pe_width: got %0d cycles edit %b expected %0d cycles edit 00", hi, EDIT, PE_CYCLES);
      end
   endtask

   task automatic test_auto_repeat();
      do_reset();
      BFM_H = 8'h12; BFM_M = 8'h00;
      press(0);
      press(0);
      KEY_INC = 1'b1;
      for (int i = 1; i <= REPEAT_DELAY + 3 * REPEAT_RATE; i++) begin
         tick();
         vectors++;
         if ({D_H, D_M, D_S, PE, EDIT} !== expv()) begin
            miscompares++;
            $display("FAIL repeat_model@%0d: got %h expected %h", i, {D_H, D_M, D_S, PE, EDIT}, expv());
         end
         if (i == REPEAT_DELAY || i == REPEAT_DELAY + 1) begin
            vectors++;
            if (D_M !== (i == REPEAT_DELAY ? 8'h01 : 8'h02)) begin
               miscompares++;
               $display("FAIL repeat_edge@%0d: got %h expected %h", i, D_M, i == REPEAT_DELAY ? 8'h01 : 8'h02);
            end
         end
      end
      vectors++;
      if (D_M !== 8'h04) begin
         miscompares++;
         $display("FAIL repeat_total: got %h expected 04", D_M);
      end
      KEY_INC = 1'b0;
      repeat (3 * REPEAT_RATE) tick();
      vectors++;
      if ({D_M, EDIT} !== {8'h04, 2'b10}) begin
         miscompares++;
         $display("FAIL repeat_release: got %h/%b expected 04/10", D_M, EDIT);
      end
   endtask

   task automatic test_timeout();
      logic pe_seen;
      do_reset();
      BFM_H = 8'h05; BFM_M = 8'h15;
      press(0);
      press(1);
      pe_seen = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) begin
         tick();
         pe_seen = pe_seen | PE;
         vectors++;
         if ({D_H, D_M, D_S, PE, EDIT} !== expv()) begin
            miscompares++;
            $display("FAIL timeout_model@%0d: got %h expected %h", i, {D_H, D_M, D_S, PE, EDIT}, expv());
         end
      end
      vectors++;
      if ({pe_seen, EDIT, D_H, D_M} !== {1'b0, 2'b00, 8'h06, 8'h15}) begin
         miscompares++;
         $display("FAIL timeout: got pe=%b edit=%b %h/%h expected pe=0 edit=00 06/15", pe_seen, EDIT, D_H, D_M);
      end
   endtask

   task automatic test_priority();
      int hi;
      do_reset();
      BFM_H = 8'h10; BFM_M = 8'h20;
      press(0);
      KEY_OK = 1'b1; KEY_MODE = 1'b1;
      tick();
      KEY_OK = 1'b0; KEY_MODE = 1'b0;
      vectors++;
      if ({PE, EDIT} !== 3'b111) begin
         miscompares++;
         $display("FAIL priority: got pe=%b edit=%b expected pe=1 edit=11", PE, EDIT);
      end
      hi = 1;
      for (int i = 0; i < 6; i++) begin
         KEY_INC = i < 3 && i[0]; KEY_MODE = i < 3 && !i[0]; KEY_OK = i == 1;
         tick();
         if (PE) hi++;
         vectors++;
         if ({D_H, D_M, D_S, PE, EDIT} !== expv() || (PE && {D_H, D_M} !== 16'h1020)) begin
            miscompares++;
            $display("FAIL load_ignore@%0d: got %h expected %h", i, {D_H, D_M, D_S, PE, EDIT}, expv());
         end
      end
      KEY_INC = 1'b0; KEY_MODE = 1'b0; KEY_OK = 1'b0;
      vectors++;
      if (hi !== PE_CYCLES || EDIT !== 2'b00) begin
         miscompares++;
         $display("FAIL pe_width_keys: got %0d cycles edit %b expected %0d cycles edit 00", hi, EDIT, PE_CYCLES);
      end
   endtask

   task automatic test_reset_mid_load();
      logic [15:0] bad [3];
      logic [15:0] good [3];
      do_reset();
      BFM_H = 8'h11; BFM_M = 8'h22;
      press(0);
      KEY_OK = 1'b1;
      tick();
      KEY_OK = 1'b0;
      tick();
      vectors++;
      if (PE !== 1'b1) begin
         miscompares++;
         $display("FAIL load_second: got pe=%b expected 1", PE);
      end
      CR_N = 1'b0;
      tick();
      vectors++;
      if ({PE, EDIT, D_H, D_M} !== 19'h0) begin
         miscompares++;
         $display("FAIL reset_mid_load: got pe=%b edit=%b %h/%h expected 0/00 00/00", PE, EDIT, D_H, D_M);
      end
      CR_N = 1'b1;
      bad  = '{16'h2A61, 16'h1A3F, 16'h2459};
      good = '{16'h0000, 16'h0000, 16'h0000};
      for (int i = 0; i < 3; i++) begin
         if (i == 2) good[i] = 16'h0059;
         do_reset();
         {BFM_H, BFM_M} = bad[i];
         press(0);
         vectors++;
         if ({D_H, D_M, EDIT} !== {good[i], 2'b01}) begin
            miscompares++;
            $display("FAIL invalid_capture%0d: got %h/%h/%b expected %h/01", i, D_H, D_M, EDIT, good[i]);
         end
      end
      do_reset();
      BFM_H = 8'h23; BFM_M = 8'h59;
      press(0);
      vectors++;
      if ({D_H, D_M} !== 16'h2359) begin
         miscompares++;
         $display("FAIL edge_capture: got %h/%h expected 23/59", D_H, D_M);
      end
   endtask

   task automatic test_random();
      int div;
      do_reset();
      for (int i = 0; i < 6000; i++) begin
         div = ((i / 1000) % 2 == 1) ? 900 : 7;
         if ($urandom_range(0, div) == 0) KEY_MODE = ~KEY_MODE;
         if ($urandom_range(0, div) == 0) KEY_INC = ~KEY_INC;
         if ($urandom_range(0, div * 3) == 0) KEY_OK = ~KEY_OK;
         if ($urandom_range(0, 3) == 0) begin
            BFM_H = 8'($urandom_range(0, 255));
            BFM_M = 8'($urandom_range(0, 255));
         end
         CR_N = $urandom_range(0, 1499) != 0;
         tick();
         vectors++;
         if ({D_H, D_M, D_S, PE, EDIT} !== expv()) begin
            miscompares++;
            $display("FAIL random@%0d: got %h expected %h", i, {D_H, D_M, D_S, PE, EDIT}, expv());
         end
      end
      CR_N = 1'b1;
   endtask

   initial begin
      test_reset();
      test_hour_wrap_commit();
      test_auto_repeat();
      test_timeout();
      test_priority();
      test_reset_mid_load();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/alarm_setter.md
Name: alarm_setter

Overview:
- Key-driven editor that produces the alarm time and the load strobe for the alarm block's preset interface: D_H, D_M, D_S and PE.
- It captures the current alarm registers, lets the user step hours and minutes in BCD, then commits by holding PE high for a fixed window.
- It sits between the debounced front-panel keys and the alarm block, in the same CP domain as the display scan.

Parameters:
- TIMEOUT, 5000: CP cycles without a key press in an edit state before the edit is abandoned.
- PE_CYCLES, 4: number of CP cycles PE is held high during commit (≥1).
- REPEAT_DELAY, 500: CP cycles KEY_INC must be held before auto-repeat starts.
- REPEAT_RATE, 100: CP cycles between auto-repeat increments.

Ports:
- CP  input  1  system clock; all logic on posedge.
- CR_N  input  1  synchronous reset, active-low.
- KEY_MODE  input  1  debounced level, CP-synchronous; enter edit / toggle field.
- KEY_INC  input  1  debounced level; increment the selected field.
- KEY_OK  input  1  debounced level; commit.
- BFM_H  input  8  current alarm hour, BCD.
- BFM_M  input  8  current alarm minute, BCD.
- D_H  output  8  working hour, BCD 00–23.
- D_M  output  8  working minute, BCD 00–59.
- D_S  output  8  constant 8'h00.
- PE  output  1  load strobe to the alarm block.
- EDIT  output  2  field indicator for display blink: 00 idle, 01 hour, 10 minute, 11 loading.

Behaviour:
- Clock and reset: one clock, CP. Reset is synchronous and active-low on CR_N, sampled at posedge CP.
- Reset values: state IDLE, D_H=D_M=D_S=8'h00, PE=0, EDIT=00, all counters 0, key history registers 0. A reset asserted mid-edit or mid-load drops PE on the next edge. Nothing is committed.
- Press detection: press_x = KEY_x & ~KEY_x_q, with KEY_x_q registered each cycle. Only rising edges act, except for INC auto-repeat.
- Simultaneous presses in the same cycle: priority OK > MODE > INC. Lower-priority presses in that cycle are dropped.
- IDLE:
  - PE=0, EDIT=00.
  - MODE press: capture BFM_H into D_H and BFM_M into D_M, then go to EDIT_H.
  - Invalid capture is replaced by 00: hour >8'h23, minute >8'h59, or any nibble >9.
  - INC and OK are ignored.
- EDIT_H (EDIT=01):
  - INC event: D_H BCD +1; 8'h09→8'h10, 8'h19→8'h20, 8'h23→8'h00.
  - MODE press: go to EDIT_M.
  - OK press: go to LOAD.
- EDIT_M (EDIT=10):
  - INC event: D_M BCD +1; x9→(x+1)0, 8'h59→8'h00.
  - MODE press: go to EDIT_H.
  - OK press: go to LOAD.
- Increment latency: D_H/D_M update on the edge that samples the event and are visible in the next cycle.
- Auto-repeat (edit states only):
  - The hold counter resets on a KEY_INC rising edge and counts while KEY_INC=1.
  - The first repeat event fires when the count reaches REPEAT_DELAY. Further events fire every REPEAT_RATE cycles after that.
  - Releasing KEY_INC clears the counter.
  - Any edit-state transition also clears it; a held INC does not repeat into the new field until it is released and pressed again.
- Timeout:
  - The idle counter clears on any press or repeat event and on entry to an edit state.
  - When it reaches TIMEOUT-1 in an edit state, the next state is IDLE.
  - D_H/D_M keep their working values, but PE is never asserted, so the alarm registers are unchanged.
- LOAD (EDIT=11):
  - PE=1 for exactly PE_CYCLES consecutive cycles, starting in the cycle after the OK press.
  - D_H/D_M are frozen while PE is high. D_S=8'h00 throughout.
  - All keys are ignored.
  - The state returns to IDLE after PE_CYCLES cycles, with PE=0 in that next cycle.
- PE is registered, glitch-free, and high only in LOAD. The alarm block's preset is level-sensitive, so D_* must be stable during the whole PE window.

Test Plan:
- Reset and capture: CR_N=0 for 2 cycles → D_H=D_M=00, PE=0, EDIT=00. Then BFM_H=8'h07, BFM_M=8'h30 and a MODE press → D_H=07, D_M=30, EDIT=01.
- Hour wrap and commit: from D_H=8'h22, give 2 INC presses → 23 then 00. MODE, 3 INC presses from M=8'h58 → 59, 00, 01. OK → PE high exactly 4 cycles with D_H=00, D_M=01, D_S=00, then EDIT=00.
- Auto-repeat: in EDIT_M from 00, hold INC for REPEAT_DELAY+3*REPEAT_RATE cycles → D_M=04 (1 press + 1 delayed repeat + 2 rate repeats, boundary-exact). Release → no further change.
- Timeout discard: enter edit, press INC once, then idle TIMEOUT cycles → EDIT=00 and PE never asserted. The alarm-side BFM values are unchanged.
- Priority and ignore: OK and MODE pressed in the same cycle in EDIT_H → LOAD, not EDIT_M. Key presses during the PE window → no effect on D_*, PE width still 4 cycles.
- Reset mid-load and invalid capture: assert CR_N=0 during the second PE cycle → PE=0 next cycle, EDIT=00. Capture with BFM_H=8'h2A, BFM_M=8'h61 → D_H=00, D_M=00.
